// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register map,
// CTRL bit positions, mode encodings, FSM states and the byte-lane merge helper.
package bus_timer_pkg;

  localparam logic [1:0] OFF_CTRL     = 2'd0;
  localparam logic [1:0] OFF_PRESET   = 2'd1;
  localparam logic [1:0] OFF_COUNT    = 2'd2;
  localparam logic [1:0] OFF_PRESCALE = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  // Replace only the byte lanes selected by be; shared with the data memory.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Compare-and-tick prescaler: tick_o pulses when the running counter matches
// prescale_i; the counter restarts on clear_i (LOAD) and on every tick.
module timer_prescaler #(
  parameter int PS_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            run_i,
  input  logic [PS_W-1:0] prescale_i,
  output logic            tick_o
);

  logic [PS_W-1:0] cnt_q;

  assign tick_o = run_i && (cnt_q == prescale_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear_i || tick_o) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= cnt_q + PS_W'(1);
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer on the CPU data port with level interrupt.
// Optional TIMER_PRESCALE_EN adds an 8-bit PRESCALE register at offset 3.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  logic [1:0]       off;
  logic             ctrl_wr, preset_wr;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_flag_q, irq_flag_d;
  state_e           state_q, state_d;
  logic             dec_tick;
  logic             unused_addr_lsb;

  assign hit             = (addr[31:4] == BASE_ADDR[31:4]);
  assign off             = addr[3:2];
  assign unused_addr_lsb = ^addr[1:0];
  assign ctrl_wr         = we && hit && (off == OFF_CTRL);
  assign preset_wr       = we && hit && (off == OFF_PRESET);
  assign irq             = irq_flag_q & ctrl_q[CTRL_IM];

`ifdef TIMER_PRESCALE_EN
  logic [7:0] prescale_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale_q <= '0;
    end else if (we && hit && (off == OFF_PRESCALE) && byteen[0]) begin
      prescale_q <= wdata[7:0];
    end
  end

  timer_prescaler #(.PS_W(8)) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (state_q == LOAD),
    .run_i      ((state_q == CNT) && ctrl_q[CTRL_EN]),
    .prescale_i (prescale_q),
    .tick_o     (dec_tick)
  );
`else
  assign dec_tick = 1'b1;
`endif

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    state_d    = state_q;
    case (state_q)
      IDLE: if (ctrl_q[CTRL_EN]) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = IDLE;
        end else if (dec_tick) begin
          if (count_q > CNT_W'(1)) begin
            count_d = count_q - CNT_W'(1);
          end else begin
            count_d = '0;
            state_d = INT;
          end
        end
      end
      INT: begin
        irq_flag_d = 1'b1;
        if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) begin
          state_d = LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Bus write lanes override the FSM's EN clear; the INT set beats the clear.
    if (ctrl_wr) begin
      ctrl_d = 4'(byte_merge({28'b0, ctrl_d}, wdata, byteen));
      if (state_q != INT) irq_flag_d = 1'b0;
    end
    if (preset_wr) preset_d = CNT_W'(byte_merge(32'(preset_q), wdata, byteen));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        OFF_CTRL:   rdata = {28'b0, ctrl_q};
        OFF_PRESET: rdata = 32'(preset_q);
        OFF_COUNT:  rdata = 32'(count_q);
`ifdef TIMER_PRESCALE_EN
        OFF_PRESCALE: rdata = {24'b0, prescale_q};
`endif
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer: reset, one-shot, auto-reload,
// byte lanes, out-of-window writes, bus-vs-FSM collisions and offset 3.
`timescale 1ns/1ps
module tb_bus_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  byteen = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  int checks = 0;
  int errors = 0;

  bus_timer #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .hit    (hit),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] d);
    addr = BASE + {28'b0, off};
    #0.2;
    d = rdata;
  endtask

  task automatic do_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr = BASE + {28'b0, off}; we = 1'b1; byteen = be; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0; byteen = '0;
    $display("write off=%h data=%h be=%b", off, d, be);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rd(4'h0, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    rd(4'h4, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_preset got=%h exp=0", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    @(negedge clk); reset = 1'b1;
    tick(); tick();
    rd(4'h8, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", d); end
    $display("test_reset done");
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    apply_reset();
    do_write(4'h4, 32'd3, 4'hF);
    do_write(4'h0, 32'h9, 4'hF);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      rd(4'h8, d);
      checks++; if (d !== 32'(3 - i)) begin errors++; $display("FAIL oneshot_count[%0d] got=%0d exp=%0d", i, d, 3 - i); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_early[%0d] got=%b exp=0", i, irq); end
      $display("oneshot step %0d count=%0d irq=%b", i, d, irq);
      if (i < 3) tick();
    end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_rise got=%b exp=1", irq); end
    rd(4'h0, d); checks++; if (d !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl got=%h exp=8", d); end
    tick(); tick(); tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_hold got=%b exp=1", irq); end
    do_write(4'h0, 32'h8, 4'hF);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear got=%b exp=0", irq); end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    int exp_cnt[8] = '{2, 1, 0, 0, 2, 1, 0, 0};
    logic exp_irq[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int exp_cnt2[4] = '{2, 1, 0, 0};
    logic exp_irq2[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    do_write(4'h4, 32'd2, 4'hF);
    do_write(4'h0, 32'hB, 4'hF);
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      rd(4'h8, d);
      checks++; if (d !== 32'(exp_cnt[i])) begin errors++; $display("FAIL reload_count[%0d] got=%0d exp=%0d", i, d, exp_cnt[i]); end
      checks++; if (irq !== exp_irq[i]) begin errors++; $display("FAIL reload_irq[%0d] got=%b exp=%b", i, irq, exp_irq[i]); end
      $display("reload step %0d count=%0d irq=%b", i, d, irq);
      if (i < 7) tick();
    end
    rd(4'h0, d); checks++; if (d !== 32'hB) begin errors++; $display("FAIL reload_ctrl got=%h exp=b", d); end
    do_write(4'h0, 32'hB, 4'hF);
    for (int i = 0; i < 4; i++) begin
      rd(4'h8, d);
      checks++; if (d !== 32'(exp_cnt2[i])) begin errors++; $display("FAIL reload2_count[%0d] got=%0d exp=%0d", i, d, exp_cnt2[i]); end
      checks++; if (irq !== exp_irq2[i]) begin errors++; $display("FAIL reload2_irq[%0d] got=%b exp=%b", i, irq, exp_irq2[i]); end
      $display("reload-after-clear step %0d count=%0d irq=%b", i, d, irq);
      if (i < 3) tick();
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    apply_reset();
    do_write(4'h4, 32'h1122_3344, 4'hF);
    do_write(4'h4, 32'hAABB_CCDD, 4'b0010);
    rd(4'h4, d); checks++; if (d !== 32'h1122_CC44) begin errors++; $display("FAIL lane_preset got=%h exp=1122cc44", d); end
    do_write(4'h8, 32'hFFFF_FFFF, 4'hF);
    rd(4'h8, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL count_ro got=%h exp=0", d); end
  endtask

  task automatic test_outside();
    logic [31:0] d;
    @(negedge clk);
    addr = BASE + 32'h10; we = 1'b1; byteen = 4'hF; wdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL out_hit got=%b exp=0", hit); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL out_rdata got=%h exp=0", rdata); end
    @(posedge clk); #1;
    we = 1'b0; byteen = '0;
    $display("write outside window addr=%h", BASE + 32'h10);
    rd(4'h4, d); checks++; if (d !== 32'h1122_CC44) begin errors++; $display("FAIL out_preset got=%h exp=1122cc44", d); end
    rd(4'h0, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL out_ctrl got=%h exp=0", d); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL in_hit got=%b exp=1", hit); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    apply_reset();
    do_write(4'h4, 32'd1, 4'hF);
    do_write(4'h0, 32'h9, 4'hF);
    tick(); tick(); tick();
    do_write(4'h0, 32'h9, 4'hF);
    rd(4'h0, d); checks++; if (d !== 32'h9) begin errors++; $display("FAIL collide_ctrl got=%h exp=9", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL collide_irq got=%b exp=1", irq); end
    apply_reset();
    do_write(4'h0, 32'h9, 4'hF);
    tick(); tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL zero_irq_early got=%b exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL zero_irq got=%b exp=1", irq); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d;
    apply_reset();
    do_write(4'h4, 32'd100, 4'hF);
    do_write(4'h0, 32'h9, 4'hF);
    repeat (62) tick();
    rd(4'h8, d); checks++; if (d !== 32'd40) begin errors++; $display("FAIL mid_count got=%0d exp=40", d); end
    #1;
    reset = 1'b0;
    rd(4'h8, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_count got=%h exp=0", d); end
    rd(4'h4, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_preset got=%h exp=0", d); end
    rd(4'h0, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_ctrl got=%h exp=0", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq got=%b exp=0", irq); end
    @(negedge clk); reset = 1'b1;
    tick(); tick(); tick();
    rd(4'h8, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_idle got=%h exp=0", d); end
    $display("reset mid-count checked");
  endtask

  task automatic test_offset3();
    logic [31:0] d;
`ifdef TIMER_PRESCALE_EN
    int exp_cnt[8] = '{2, 2, 2, 1, 1, 1, 0, 0};
    logic exp_irq[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    do_write(4'hC, 32'd2, 4'hF);
    rd(4'hC, d); checks++; if (d !== 32'd2) begin errors++; $display("FAIL prescale_rd got=%h exp=2", d); end
    do_write(4'h4, 32'd2, 4'hF);
    do_write(4'h0, 32'h9, 4'hF);
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      rd(4'h8, d);
      checks++; if (d !== 32'(exp_cnt[i])) begin errors++; $display("FAIL ps_count[%0d] got=%0d exp=%0d", i, d, exp_cnt[i]); end
      checks++; if (irq !== exp_irq[i]) begin errors++; $display("FAIL ps_irq[%0d] got=%b exp=%b", i, irq, exp_irq[i]); end
      $display("prescale step %0d count=%0d irq=%b", i, d, irq);
      if (i < 7) tick();
    end
`else
    apply_reset();
    do_write(4'hC, 32'hFF, 4'hF);
    rd(4'hC, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL off3_rd got=%h exp=0", d); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL off3_hit got=%b exp=1", hit); end
`endif
  endtask

  initial begin
    #2;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_byte_lanes();
    test_outside();
    test_collision();
    test_reset_midcount();
    test_offset3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
